// File: rtl/ddr3_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_cmd_monitor
// Description : Passive DDR3 command-bus decoder and protocol checker. Samples
//               the controller's command pins once per clock, decodes the
//               command, tracks per-bank open-row state and refresh/MRS
//               timing, and flags protocol violations.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               address, bank_address, ck_en, cs_n, ras_n, cas_n, we_n,
//               reset_n              - observed DDR3 command pins
//               cmd_valid/code/bank/addr - registered decoded command
//               bank_open            - bit per bank, row open
//               err_pulse, err_sticky - violation flags
//               act/rd/wr_count      - saturating legal-command counters
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_cmd_monitor #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int T_RCD                 = 1,
    parameter int T_RP                  = 1,
    parameter int T_RFC                 = 8,
    parameter int T_MRD                 = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ADDRESS_BITWIDTH-1:0]           address,
    input  logic [BANK_ADDRESS_BITWIDTH-1:0]      bank_address,
    input  logic                                  ck_en,
    input  logic                                  cs_n,
    input  logic                                  ras_n,
    input  logic                                  cas_n,
    input  logic                                  we_n,
    input  logic                                  reset_n,
    output logic                                  cmd_valid,
    output logic [3:0]                            cmd_code,
    output logic [BANK_ADDRESS_BITWIDTH-1:0]      cmd_bank,
    output logic [ADDRESS_BITWIDTH-1:0]           cmd_addr,
    output logic [(1<<BANK_ADDRESS_BITWIDTH)-1:0] bank_open,
    output logic [5:0]                            err_pulse,
    output logic                                  err_sticky,
    output logic [15:0]                           act_count,
    output logic [15:0]                           rd_count,
    output logic [15:0]                           wr_count
);

    localparam int c_NUM_BANKS = 1 << BANK_ADDRESS_BITWIDTH;
    localparam int c_TIMER_W   = 8;

    // Timers reload with T-1 so that a timer reading zero on the edge a
    // command arrives means "k >= T cycles have elapsed".
    localparam logic [c_TIMER_W-1:0] c_RCD_LOAD  = c_TIMER_W'((T_RCD > 1) ? T_RCD - 1 : 0);
    localparam logic [c_TIMER_W-1:0] c_RP_LOAD   = c_TIMER_W'((T_RP  > 1) ? T_RP  - 1 : 0);
    localparam logic [c_TIMER_W-1:0] c_RFC_LOAD  = c_TIMER_W'((T_RFC > 1) ? T_RFC - 1 : 0);
    localparam logic [c_TIMER_W-1:0] c_MRD_LOAD  = c_TIMER_W'((T_MRD > 1) ? T_MRD - 1 : 0);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);

    localparam logic [3:0] c_CMD_NOP  = 4'd0;
    localparam logic [3:0] c_CMD_ACT  = 4'd1;
    localparam logic [3:0] c_CMD_PRE  = 4'd2;
    localparam logic [3:0] c_CMD_PREA = 4'd3;
    localparam logic [3:0] c_CMD_RD   = 4'd4;
    localparam logic [3:0] c_CMD_WR   = 4'd5;
    localparam logic [3:0] c_CMD_REF  = 4'd6;
    localparam logic [3:0] c_CMD_MRS  = 4'd7;
    localparam logic [3:0] c_CMD_ZQCL = 4'd8;
    localparam logic [3:0] c_CMD_DES  = 4'd15;

    localparam logic [1:0] c_BANK_IDLE        = 2'd0;
    localparam logic [1:0] c_BANK_ACTIVATING  = 2'd1;
    localparam logic [1:0] c_BANK_ACTIVE      = 2'd2;
    localparam logic [1:0] c_BANK_PRECHARGING = 2'd3;

    localparam logic [1:0] c_GLB_NORMAL     = 2'd0;
    localparam logic [1:0] c_GLB_REFRESHING = 2'd1;
    localparam logic [1:0] c_GLB_MRS_WAIT   = 2'd2;

    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                       r_bank_state [c_NUM_BANKS];
    logic [c_TIMER_W-1:0]             r_bank_timer [c_NUM_BANKS];
    logic [1:0]                       r_glb_state;
    logic [c_TIMER_W-1:0]             r_glb_timer;

    logic                             r_cmd_valid;
    logic [3:0]                       r_cmd_code;
    logic [BANK_ADDRESS_BITWIDTH-1:0] r_cmd_bank;
    logic [ADDRESS_BITWIDTH-1:0]      r_cmd_addr;
    logic [5:0]                       r_err_pulse;
    logic                             r_err_sticky;
    logic [15:0]                      r_act_count;
    logic [15:0]                      r_rd_count;
    logic [15:0]                      r_wr_count;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_suppress;
    logic [3:0] w_code;
    logic       w_valid;

    assign w_suppress = !ck_en || !reset_n;

    always_comb begin
        w_code = c_CMD_DES;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b111: w_code = c_CMD_NOP;
                3'b011: w_code = c_CMD_ACT;
                3'b010: w_code = address[10] ? c_CMD_PREA : c_CMD_PRE;
                3'b101: w_code = c_CMD_RD;
                3'b100: w_code = c_CMD_WR;
                3'b001: w_code = c_CMD_REF;
                3'b000: w_code = c_CMD_MRS;
                3'b110: w_code = c_CMD_ZQCL;
                default: w_code = c_CMD_DES;
            endcase
        end
    end

    assign w_valid = !w_suppress && (w_code != c_CMD_NOP) && (w_code != c_CMD_DES);

    // ------------------------------------------------------------------
    // Effective bank status: a timer at zero counts as already expired.
    // ------------------------------------------------------------------
    logic [c_NUM_BANKS-1:0] w_bank_open;
    logic [c_NUM_BANKS-1:0] w_bank_idle;
    logic [c_NUM_BANKS-1:0] w_bank_ready;
    logic [c_NUM_BANKS-1:0] w_bank_sel;

    generate
        for (genvar g = 0; g < c_NUM_BANKS; g++) begin : g_bank
            assign w_bank_open[g]  = (r_bank_state[g] == c_BANK_ACTIVATING) ||
                                     (r_bank_state[g] == c_BANK_ACTIVE);
            assign w_bank_idle[g]  = (r_bank_state[g] == c_BANK_IDLE) ||
                                     ((r_bank_state[g] == c_BANK_PRECHARGING) &&
                                      (r_bank_timer[g] == '0));
            assign w_bank_ready[g] = (r_bank_state[g] == c_BANK_ACTIVE) ||
                                     ((r_bank_state[g] == c_BANK_ACTIVATING) &&
                                      (r_bank_timer[g] == '0));
            assign w_bank_sel[g]   = (bank_address == BANK_ADDRESS_BITWIDTH'(g));
        end
    endgenerate

    logic       w_any_open;
    logic       w_rfc_busy;
    logic       w_mrd_busy;
    logic [5:0] w_err;
    logic       w_legal;

    assign w_any_open = |w_bank_open;
    assign w_rfc_busy = (r_glb_state == c_GLB_REFRESHING) && (r_glb_timer != '0);
    assign w_mrd_busy = (r_glb_state == c_GLB_MRS_WAIT)   && (r_glb_timer != '0);

    always_comb begin
        w_err = '0;
        if (w_valid) begin
            w_err[0] = (w_code == c_CMD_ACT) && !w_bank_idle[bank_address];
            w_err[1] = ((w_code == c_CMD_RD) || (w_code == c_CMD_WR)) &&
                       !w_bank_ready[bank_address];
            w_err[2] = (w_code == c_CMD_REF) && w_any_open;
            w_err[3] = w_rfc_busy;
            w_err[4] = w_mrd_busy;
            w_err[5] = ((w_code == c_CMD_MRS) || (w_code == c_CMD_ZQCL)) && w_any_open;
        end
    end

    assign w_legal = w_valid && (w_err == '0);

    // ------------------------------------------------------------------
    // Per-bank FSMs. Illegal commands never reach here (w_legal gates them).
    // With ck_en low the states hold but the timers keep running.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int b = 0; b < c_NUM_BANKS; b++) begin
            if (reset || !reset_n) begin
                r_bank_state[b] <= c_BANK_IDLE;
                r_bank_timer[b] <= '0;
            end else begin
                if (r_bank_timer[b] != '0) begin
                    r_bank_timer[b] <= r_bank_timer[b] - c_TIMER_ONE;
                end
                if (ck_en) begin
                    if (w_legal && (w_code == c_CMD_ACT) && w_bank_sel[b]) begin
                        r_bank_state[b] <= c_BANK_ACTIVATING;
                        r_bank_timer[b] <= c_RCD_LOAD;
                    end else if (w_legal && w_bank_open[b] &&
                                 ((w_code == c_CMD_PREA) ||
                                  ((w_code == c_CMD_PRE) && w_bank_sel[b]))) begin
                        r_bank_state[b] <= c_BANK_PRECHARGING;
                        r_bank_timer[b] <= c_RP_LOAD;
                    end else if ((r_bank_state[b] == c_BANK_ACTIVATING) &&
                                 (r_bank_timer[b] == '0)) begin
                        r_bank_state[b] <= c_BANK_ACTIVE;
                    end else if ((r_bank_state[b] == c_BANK_PRECHARGING) &&
                                 (r_bank_timer[b] == '0)) begin
                        r_bank_state[b] <= c_BANK_IDLE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Global refresh / mode-register FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || !reset_n) begin
            r_glb_state <= c_GLB_NORMAL;
            r_glb_timer <= '0;
        end else begin
            if (r_glb_timer != '0) begin
                r_glb_timer <= r_glb_timer - c_TIMER_ONE;
            end
            if (w_legal && (w_code == c_CMD_REF)) begin
                r_glb_state <= c_GLB_REFRESHING;
                r_glb_timer <= c_RFC_LOAD;
            end else if (w_legal && (w_code == c_CMD_MRS)) begin
                r_glb_state <= c_GLB_MRS_WAIT;
                r_glb_timer <= c_MRD_LOAD;
            end else if ((r_glb_state != c_GLB_NORMAL) && (r_glb_timer == '0)) begin
                r_glb_state <= c_GLB_NORMAL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered command report, error flags and counters.
    // Counters and the sticky flag survive reset_n; only reset clears them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= c_CMD_DES;
            r_cmd_bank   <= '0;
            r_cmd_addr   <= '0;
            r_err_pulse  <= '0;
            r_err_sticky <= 1'b0;
            r_act_count  <= '0;
            r_rd_count   <= '0;
            r_wr_count   <= '0;
        end else begin
            r_cmd_valid  <= w_valid;
            r_cmd_code   <= w_suppress ? c_CMD_DES : w_code;
            r_cmd_bank   <= w_suppress ? '0 : bank_address;
            r_cmd_addr   <= w_suppress ? '0 : address;
            r_err_pulse  <= w_err;
            r_err_sticky <= r_err_sticky || (w_err != '0);
            if (w_legal && (w_code == c_CMD_ACT) && (r_act_count != c_COUNT_MAX)) begin
                r_act_count <= r_act_count + 16'd1;
            end
            if (w_legal && (w_code == c_CMD_RD) && (r_rd_count != c_COUNT_MAX)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_legal && (w_code == c_CMD_WR) && (r_wr_count != c_COUNT_MAX)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_code   = r_cmd_code;
    assign cmd_bank   = r_cmd_bank;
    assign cmd_addr   = r_cmd_addr;
    assign bank_open  = w_bank_open;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign act_count  = r_act_count;
    assign rd_count   = r_rd_count;
    assign wr_count   = r_wr_count;

endmodule
`default_nettype wire
